// File: rtl/cla_add_scheduler.sv
// Shares one external 16-bit CLA between two requesters: round-robin grant, WORDS slices chained
// through a carry register, result held on rsp_* until rsp_ready (no new grant while busy).
module cla_add_scheduler #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic [16*WORDS-1:0]   opa0,
   input  logic [16*WORDS-1:0]   opb0,
   input  logic                  sub0,
   input  logic                  req1,
   input  logic [16*WORDS-1:0]   opa1,
   input  logic [16*WORDS-1:0]   opb1,
   input  logic                  sub1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic [15:0]           add_a,
   output logic [15:0]           add_b,
   output logic                  add_cin,
   input  logic [15:0]           add_sum,
   input  logic                  add_cout,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [16*WORDS-1:0]   rsp_result,
   output logic                  rsp_cout,
   output logic                  rsp_ovf,
   output logic                  rsp_id
);

   localparam int W  = 16 * WORDS;
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    result;
   logic            sub_q;
   logic            carry_q;
   logic            id_q;
   logic            last_id;
   logic            win;

   // A lone requester wins; on a tie the one that was not served last wins.
   assign win = (req0 && req1) ? ~last_id : req1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         k       <= '0;
         a_q     <= '0;
         b_q     <= '0;
         result  <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         id_q    <= 1'b0;
         last_id <= 1'b1;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  a_q     <= win ? opa1 : opa0;
                  b_q     <= win ? (sub1 ? ~opb1 : opb1) : (sub0 ? ~opb0 : opb0);
                  sub_q   <= win ? sub1 : sub0;
                  id_q    <= win;
                  last_id <= win;
                  k       <= '0;
                  gnt0    <= ~win;
                  gnt1    <= win;
                  state   <= RUN;
               end
            end
            RUN: begin
               result[16*k +: 16] <= add_sum;
               carry_q            <= add_cout;
               k                  <= k + 1'b1;
               if (k == KW'(WORDS - 1)) begin
                  state <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Slice 0 takes the subtract flag as carry-in (two's complement +1); later slices use the
   // registered carry so the external adder never sees a combinational loop through us.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_a   = a_q[16*k +: 16];
         add_b   = b_q[16*k +: 16];
         add_cin = (k == '0) ? sub_q : carry_q;
      end
   end

   assign rsp_valid  = (state == RESP);
   assign rsp_result = result;
   assign rsp_cout   = carry_q;
   assign rsp_id     = id_q;
   assign rsp_ovf    = (state == RESP) && (a_q[W-1] == b_q[W-1]) && (result[W-1] != a_q[W-1]);

endmodule
